// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// segment ordering and a counter-width helper.
package seg7_pkg;

  // Patterns are {a,b,c,d,e,f,g}; bit 6 drives segment a.
  localparam logic [8*7-1:0] SEG_ORDER = "abcdefg";

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to seven-segment decoder; hex_i selects hexadecimal glyphs,
// otherwise values above 9 show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = hex_i ? SEG_A : SEG_DASH;
      4'hB:    seg_o = hex_i ? SEG_B : SEG_DASH;
      4'hC:    seg_o = hex_i ? SEG_C : SEG_DASH;
      4'hD:    seg_o = hex_i ? SEG_D : SEG_DASH;
      4'hE:    seg_o = hex_i ? SEG_E : SEG_DASH;
      4'hF:    seg_o = hex_i ? SEG_F : SEG_DASH;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with tear-free frame updates.
// Define SEG7_BLANK_EN to enable leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   iValue,
  input  logic                  iLoad,
  input  logic [DIGITS-1:0]     iDp,
  input  logic                  iHex,
  input  logic                  iEnable,
  output logic [6:0]            oSeg,
  output logic                  oDp,
  output logic [DIGITS-1:0]     oAn,
  output logic                  oFrame
);

  localparam int CNT_W = width_for(SCAN_DIV);
  localparam int IDX_W = width_for(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] hold_val_q, hold_val_d;
  logic [DIGITS-1:0]   hold_dp_q, hold_dp_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                tick;
  logic                wrap;
  logic [3:0]          nib [DIGITS];
  logic [3:0]          cur_nib;
  logic [6:0]          dec_seg;
  logic                lead_blank;
  logic [6:0]          seg_lit;

  assign tick = iEnable && (cnt_q == CNT_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib[gi] = act_val_q[4*gi +: 4];
  end

  assign cur_nib = nib[idx_q];

  seg7_decode u_decode (
    .nibble_i (cur_nib),
    .hex_i    (iHex),
    .seg_o    (dec_seg)
  );

`ifdef SEG7_BLANK_EN
  // lz[k]: nibble k and every nibble above it are zero.
  logic [DIGITS-1:0] lz;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    assign lz[gi] = (act_val_q[4*DIGITS-1 : 4*gi] == '0);
  end
  assign lead_blank = (idx_q != '0) && lz[idx_q];
`else
  assign lead_blank = 1'b0;
`endif

  assign seg_lit = lead_blank ? SEG_BLANK : dec_seg;

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    hold_val_d = hold_val_q;
    hold_dp_d  = hold_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    seg_d      = SEG_BLANK;
    dp_d       = 1'b0;
    an_d       = '0;
    frame_d    = 1'b0;

    if (iLoad) begin
      hold_val_d = iValue;
      hold_dp_d  = iDp;
    end

    if (!iEnable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick) begin
      // Outputs stay dark for the cycle after the index moves (anti-ghosting).
      cnt_d   = '0;
      idx_d   = wrap ? '0 : idx_q + 1'b1;
      frame_d = wrap;
      if (wrap) begin
        act_val_d = iLoad ? iValue : hold_val_q;
        act_dp_d  = iLoad ? iDp    : hold_dp_q;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      seg_d = seg_lit;
      dp_d  = act_dp_q[idx_q];
      an_d  = DIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      hold_val_q <= '0;
      hold_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b0;
      an_q       <= '0;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      hold_val_q <= hold_val_d;
      hold_dp_q  <= hold_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign oSeg   = seg_q;
  assign oDp    = dp_q;
  assign oAn    = an_q;
  assign oFrame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4): expected
// digit slots are queued when data is loaded and popped as each slot lights.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] iValue;
  logic        iLoad;
  logic [3:0]  iDp;
  logic        iHex;
  logic        iEnable;
  logic [6:0]  oSeg;
  logic        oDp;
  logic [3:0]  oAn;
  logic        oFrame;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iValue  (iValue),
    .iLoad   (iLoad),
    .iDp     (iDp),
    .iHex    (iHex),
    .iEnable (iEnable),
    .oSeg    (oSeg),
    .oDp     (oDp),
    .oAn     (oAn),
    .oFrame  (oFrame)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] n, input logic hex);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1110011;
      4'hA: return hex ? 7'b1110111 : 7'b0000001;
      4'hB: return hex ? 7'b0011111 : 7'b0000001;
      4'hC: return hex ? 7'b1001110 : 7'b0000001;
      4'hD: return hex ? 7'b0111101 : 7'b0000001;
      4'hE: return hex ? 7'b1001111 : 7'b0000001;
      default: return hex ? 7'b1000111 : 7'b0000001;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic hex);
    exp_t e;
    logic blank;
    for (int k = 0; k < 4; k++) begin
      blank = 1'b0;
`ifdef SEG7_BLANK_EN
      if (k > 0 && (v >> (4*k)) == 16'h0) blank = 1'b1;
`endif
      e.an  = 4'(1 << k);
      e.seg = blank ? 7'b0 : ref_seg(v[4*k +: 4], hex);
      e.dp  = d[k];
      sb.push_back(e);
    end
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({oAn, oSeg, oDp, oFrame} !== 13'b0) begin
      n_fail++;
      $display("FAIL %s: an=%b seg=%b dp=%b frame=%b, required all zero",
               name, oAn, oSeg, oDp, oFrame);
    end
  endtask

  // Called at the negedge of a frame's first (blank) cycle; returns at the
  // negedge of the frame's last cycle, which is the wrap-tick cycle.
  task automatic check_frame(input logic exp_f0, input int load_at,
                             input logic [15:0] lv, input logic [3:0] ld);
    exp_t e;
    e.an = '0; e.seg = '0; e.dp = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (oFrame !== ((i == 0) ? exp_f0 : 1'b0)) begin
        n_fail++;
        $display("FAIL frame_pulse: slot cycle %0d oFrame=%b required %b",
                 i, oFrame, (i == 0) ? exp_f0 : 1'b0);
      end
      if (i % 4 == 0) begin
        n_checks++;
        if ({oAn, oSeg, oDp} !== 12'b0) begin
          n_fail++;
          $display("FAIL blank_cycle: cycle %0d an=%b seg=%b dp=%b required 0",
                   i, oAn, oSeg, oDp);
        end
      end else begin
        if (i % 4 == 1) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: cycle %0d an=%b seg=%b", i, oAn, oSeg);
          end else begin
            e = sb.pop_front();
          end
        end
        n_checks++;
        if ({oAn, oSeg, oDp} !== {e.an, e.seg, e.dp}) begin
          n_fail++;
          $display("FAIL lit_digit: cycle %0d got an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                   i, oAn, oSeg, oDp, e.an, e.seg, e.dp);
        end else if (i % 4 == 1) begin
          $display("digit an=%b seg=%b dp=%b ok", oAn, oSeg, oDp);
        end
      end
      if (i == load_at) begin
        iValue = lv;
        iDp    = ld;
        iLoad  = 1'b1;
      end else begin
        iLoad  = 1'b0;
      end
    end
  endtask

  task automatic load_at_wrap(input logic [15:0] v, input logic [3:0] d, input logic hex);
    iValue = v;
    iDp    = d;
    iHex   = hex;
    iLoad  = 1'b1;
    push_frame(v, d, hex);
    @(negedge clk);
    iLoad = 1'b0;
    check_frame(1'b1, -1, 16'h0, 4'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    push_frame(16'h0000, 4'h0, 1'b0);
    rst_n = 1'b1;
    check_frame(1'b0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_bcd();
    load_at_wrap(16'h1234, 4'h0, 1'b0);
    push_frame(16'h1234, 4'h0, 1'b0);
    @(negedge clk);
    check_frame(1'b1, -1, 16'h0, 4'h0);
  endtask

  task automatic test_hex_midframe();
    iHex = 1'b1;
    push_frame(16'h1234, 4'h0, 1'b1);
    @(negedge clk);
    check_frame(1'b1, 5, 16'h00AF, 4'h0);
    push_frame(16'h00AF, 4'h0, 1'b1);
    @(negedge clk);
    check_frame(1'b1, -1, 16'h0, 4'h0);
    iHex = 1'b0;
    push_frame(16'h00AF, 4'h0, 1'b0);
    @(negedge clk);
    check_frame(1'b1, -1, 16'h0, 4'h0);
  endtask

  task automatic test_blank();
    load_at_wrap(16'h0007, 4'h0, 1'b0);
  endtask

  task automatic test_enable();
    repeat (6) @(negedge clk);
    iEnable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_zero("disabled");
      if (i == 3) begin
        iValue = 16'h0042;
        iLoad  = 1'b1;
      end else begin
        iLoad  = 1'b0;
      end
    end
    @(negedge clk);
    iEnable = 1'b1;
    push_frame(16'h0007, 4'h0, 1'b0);
    check_frame(1'b0, -1, 16'h0, 4'h0);
    push_frame(16'h0042, 4'h0, 1'b0);
    @(negedge clk);
    check_frame(1'b1, -1, 16'h0, 4'h0);
  endtask

  task automatic test_dp();
    load_at_wrap(16'h5678, 4'b0100, 1'b0);
  endtask

  task automatic test_reset_midframe();
    repeat (10) @(negedge clk);
    n_checks++;
    if (oAn !== 4'b0100 || oDp !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_dp: an=%b dp=%b required an=0100 dp=1", oAn, oDp);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("reset_midframe");
    @(negedge clk);
    check_zero("reset_midframe_hold");
    @(negedge clk);
    push_frame(16'h0000, 4'h0, 1'b0);
    rst_n = 1'b1;
    check_frame(1'b0, -1, 16'h0, 4'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    iValue  = 16'h0;
    iLoad   = 1'b0;
    iDp     = 4'h0;
    iHex    = 1'b0;
    iEnable = 1'b1;
    test_reset();
    test_bcd();
    test_hex_midframe();
    test_blank();
    test_enable();
    test_dp();
    test_reset_midframe();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
